// File: rtl/counter_pkg.sv
// Shared types for the programmable counter: count modes and one-shot FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package counter_pkg;

    // Terminal behaviour; encoding 3 is reserved and behaves as CNT_WRAP.
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2,
        CNT_RSVD    = 2'd3
    } count_mode_t;

    // One-shot control FSM; wrap and saturate modes leave it parked in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    // Fold the reserved encoding onto wrap so the datapath only sees three modes.
    function automatic count_mode_t effective_mode(input logic [1:0] raw);
        count_mode_t m;
        m = count_mode_t'(raw);
        if (m == CNT_RSVD) begin
            m = CNT_WRAP;
        end
        return m;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated divider: asserts tick on one of every prescale+1 enabled cycles.
// Latency: tick is combinational from the divider register and the enable input.
// Backpressure: none; enable low freezes the divider, restart zeroes it.
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] div_q;
    logic [PRESCALE_W-1:0] div_d;

    // A tick fires on the enabled cycle where the divider has reached the programmed value.
    assign tick = enable && (div_q == prescale);

    // Divider next state: restart wins, otherwise wrap on tick or advance while enabled.
    always_comb begin
        div_d = div_q;
        if (restart) begin
            div_d = '0;
        end else if (enable) begin
            if (tick) begin
                div_d = '0;
            end else begin
                div_d = div_q + PRE_ONE;
            end
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Prescaled up/down counter with programmable limit and wrap/saturate/one-shot terminal behaviour.
// Latency: a step appears on counter_output one cycle after its tick edge; tc aligns with that value.
// Backpressure: none; enable low holds prescaler and count, clear > load > step each cycle.
module prog_counter
    import counter_pkg::*;
#(
    parameter int                  WIDTH       = 8,
    parameter int                  PRESCALE_W  = 8,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      counter_output,
    output logic                  tc,
    output logic                  done,
    output logic                  running
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    cnt_state_t       state_q;
    cnt_state_t       state_d;
    logic             tc_q;
    logic             tc_d;
    logic             done_q;
    logic             done_d;

    count_mode_t      mode_e;
    logic             tick;
    logic             step;
    logic             terminal;

    // Any clear or load realigns the divider so the next step is a full period away.
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .restart  (clear | load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Decode the mode, the terminal condition and whether this tick is allowed to step.
    always_comb begin
        mode_e   = effective_mode(mode);
        // Up-count treats anything at or above limit as terminal, covering loads past it
        // and a limit lowered beneath the current count.
        terminal = dir ? (count_q >= limit) : (count_q == '0);
        step     = tick && ((mode_e != CNT_ONESHOT) || (state_q == RUN));
    end

    // Next-state for count, FSM, tc and done with clear > load > step priority.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (clear) begin
            count_d = '0;
            state_d = IDLE;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_value;
            if (mode_e == CNT_ONESHOT) begin
                state_d = RUN;
                done_d  = 1'b0;
            end
        end else if (step) begin
            if (!terminal) begin
                count_d = dir ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
            end else begin
                tc_d = 1'b1;
                case (mode_e)
                    CNT_SAT: begin
                        count_d = count_q;
                    end
                    CNT_ONESHOT: begin
                        // Count holds; leaving RUN stops further steps, so tc fires once.
                        count_d = count_q;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                    default: begin
                        count_d = dir ? '0 : limit;
                    end
                endcase
            end
        end
    end

    // State registers; reset discards any count or one-shot in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RESET_VALUE;
            state_q <= IDLE;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign counter_output = count_q;
    assign tc             = tc_q;
    assign done           = done_q;
    assign running        = (state_q == RUN);

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Ends with a single pass-count summary line.
module tb_prog_counter;
    import counter_pkg::*;

    localparam int W  = 8;
    localparam int PW = 8;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          clear;
    logic          load;
    logic [W-1:0]  load_value;
    logic [W-1:0]  limit;
    logic          dir;
    logic [1:0]    mode;
    logic [PW-1:0] prescale;
    logic [W-1:0]  counter_output;
    logic          tc;
    logic          done;
    logic          running;

    int n_checks;
    int n_pass;

    logic [7:0] exp_wrap_c  [7];
    logic       exp_wrap_tc [7];
    logic [7:0] exp_dn_c    [9];
    logic       exp_dn_tc   [9];

    prog_counter #(
        .WIDTH       (W),
        .PRESCALE_W  (PW),
        .RESET_VALUE (8'd120)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .clear          (clear),
        .load           (load),
        .load_value     (load_value),
        .limit          (limit),
        .dir            (dir),
        .mode           (mode),
        .prescale       (prescale),
        .counter_output (counter_output),
        .tc             (tc),
        .done           (done),
        .running        (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load       = 1'b1;
        load_value = v;
        step_clk();
        load       = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        exp_wrap_c  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        exp_wrap_tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_dn_c    = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd3, 8'd3, 8'd3, 8'd2};
        exp_dn_tc   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n    = 1'b1;
        enable     = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        limit      = '0;
        dir        = 1'b1;
        mode       = CNT_WRAP;
        prescale   = '0;

        // Reset values
        #1 reset_n = 1'b0;
        #2;
        check("rst_count", counter_output, 120);
        check("rst_tc", tc, 0);
        check("rst_done", done, 0);
        check("rst_running", running, 0);
        step_clk();
        check("rst_hold_count", counter_output, 120);
        @(negedge clk);
        reset_n = 1'b1;
        step_clk();
        check("post_rst_count", counter_output, 120);

        // Wrap up, limit 5, prescale 0
        mode     = CNT_WRAP;
        dir      = 1'b1;
        limit    = 8'd5;
        prescale = 8'd0;
        clear    = 1'b1;
        step_clk();
        clear    = 1'b0;
        check("wrap_clr_count", counter_output, 0);
        enable   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step_clk();
            check($sformatf("wrap_up_c%0d", i), counter_output, exp_wrap_c[i]);
            check($sformatf("wrap_up_tc%0d", i), tc, exp_wrap_tc[i]);
        end

        // Wrap down, limit 3, prescale 2, load 1
        enable   = 1'b0;
        dir      = 1'b0;
        limit    = 8'd3;
        prescale = 8'd2;
        do_load(8'd1);
        check("dn_load_count", counter_output, 1);
        enable   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step_clk();
            check($sformatf("wrap_dn_c%0d", i), counter_output, exp_dn_c[i]);
            check($sformatf("wrap_dn_tc%0d", i), tc, exp_dn_tc[i]);
        end

        // Saturate up, limit 250
        enable   = 1'b0;
        mode     = CNT_SAT;
        dir      = 1'b1;
        limit    = 8'd250;
        prescale = 8'd0;
        do_load(8'd248);
        check("sat_load", counter_output, 248);
        enable = 1'b1;
        step_clk(); check("sat_c249", counter_output, 249); check("sat_tc249", tc, 0);
        step_clk(); check("sat_c250", counter_output, 250); check("sat_tc250", tc, 0);
        step_clk(); check("sat_hold1", counter_output, 250); check("sat_tc_h1", tc, 1);
        step_clk(); check("sat_hold2", counter_output, 250); check("sat_tc_h2", tc, 1);
        enable = 1'b0;
        do_load(8'd255);
        check("sat_load255", counter_output, 255);
        check("sat_load255_tc", tc, 0);
        enable = 1'b1;
        step_clk(); check("sat_above_c", counter_output, 255); check("sat_above_tc", tc, 1);
        step_clk(); check("sat_above_c2", counter_output, 255); check("sat_above_tc2", tc, 1);

        // One-shot down from 4
        enable = 1'b0;
        mode   = CNT_ONESHOT;
        dir    = 1'b0;
        do_load(8'd4);
        check("os_load_c", counter_output, 4);
        check("os_load_run", running, 1);
        check("os_load_done", done, 0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_clk();
            check($sformatf("os_c%0d", i), counter_output, 3 - i);
            check($sformatf("os_tc%0d", i), tc, 0);
            check($sformatf("os_run%0d", i), running, 1);
        end
        step_clk();
        check("os_end_c", counter_output, 0);
        check("os_end_tc", tc, 1);
        check("os_end_done", done, 1);
        check("os_end_run", running, 0);
        step_clk();
        check("os_after_c", counter_output, 0);
        check("os_after_tc", tc, 0);
        check("os_after_done", done, 1);
        do_load(8'd2);
        check("os_reload_c", counter_output, 2);
        check("os_reload_run", running, 1);
        check("os_reload_done", done, 0);
        check("os_reload_tc", tc, 0);
        step_clk();
        check("os_reload_step", counter_output, 1);
        clear = 1'b1;
        step_clk();
        clear = 1'b0;
        check("os_clr_c", counter_output, 0);
        check("os_clr_run", running, 0);
        check("os_clr_done", done, 0);
        step_clk();
        check("os_idle_hold", counter_output, 0);

        // Collisions
        enable = 1'b0;
        mode   = CNT_WRAP;
        dir    = 1'b1;
        limit  = 8'd10;
        do_load(8'd10);
        check("col_pre_c", counter_output, 10);
        enable = 1'b1;
        do_load(8'd3);
        check("col_ld_tick_c", counter_output, 3);
        check("col_ld_tick_tc", tc, 0);
        step_clk();
        check("col_next_c", counter_output, 4);
        enable     = 1'b0;
        mode       = CNT_ONESHOT;
        clear      = 1'b1;
        load       = 1'b1;
        load_value = 8'd9;
        step_clk();
        clear      = 1'b0;
        load       = 1'b0;
        check("col_clr_ld_c", counter_output, 0);
        check("col_clr_ld_run", running, 0);

        // Reset in the middle of a one-shot
        mode = CNT_ONESHOT;
        dir  = 1'b0;
        do_load(8'd50);
        enable = 1'b1;
        step_clk();
        step_clk();
        check("mid_pre_c", counter_output, 48);
        reset_n = 1'b0;
        #1;
        check("mid_rst_c", counter_output, 120);
        check("mid_rst_run", running, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_tc", tc, 0);
        step_clk();
        check("mid_rst_hold", counter_output, 120);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step_clk();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
